// File: rtl/ref_clk_train_pkg.sv
// Shared FSM encoding and default parameter values for the reference-clock
// lane training controller.
package ref_clk_train_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    CLEAR,
    SETTLE,
    SAMPLE,
    STEP,
    CENTER,
    NEXT,
    FINISH
  } train_state_e;

  localparam int         DEF_NUM_LANES     = 1;
  localparam int         DEF_TAP_W         = 7;
  localparam int         DEF_SETTLE_CYCLES = 4;
  localparam int         DEF_MIN_WIN       = 3;
  localparam logic [7:0] DEF_PATTERN       = 8'h55;

endpackage

// File: rtl/ref_clk_train_window.sv
// Tracks the clean-eye window of the lane being scanned and derives the
// centre tap; outputs already include the sample being taken this cycle.
module ref_clk_train_window
  import ref_clk_train_pkg::*;
#(
  parameter int TAP_W   = DEF_TAP_W,
  parameter int MIN_WIN = DEF_MIN_WIN
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             restart,
  input  logic             sample,
  input  logic             clean,
  input  logic [TAP_W-1:0] tap,
  output logic             closed,
  output logic             win_ok,
  output logic [TAP_W-1:0] centre
);

  localparam logic [TAP_W:0] ONE_W   = (TAP_W+1)'(1);
  localparam logic [TAP_W:0] MIN_W_V = (TAP_W+1)'(MIN_WIN);

  logic             has_start_q, has_start_n, closed_q;
  logic [TAP_W-1:0] start_q, start_n, end_q, end_n;
  logic [TAP_W:0]   span;

  always_comb begin
    has_start_n = has_start_q;
    start_n     = start_q;
    end_n       = end_q;
    closed      = closed_q;
    if (sample && !closed_q) begin
      if (clean) begin
        has_start_n = 1'b1;
        end_n       = tap;
        if (!has_start_q) start_n = tap;
      end else if (has_start_q) begin
        closed = 1'b1;
      end
    end
  end

  // One extra bit so end-start+1 can never wrap at the top tap.
  assign span   = {1'b0, end_n} - {1'b0, start_n};
  assign win_ok = has_start_n && ((span + ONE_W) >= MIN_W_V);
  assign centre = start_n + span[TAP_W:1];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      has_start_q <= 1'b0;
      closed_q    <= 1'b0;
      start_q     <= '0;
      end_q       <= '0;
    end else if (restart) begin
      has_start_q <= 1'b0;
      closed_q    <= 1'b0;
      start_q     <= '0;
      end_q       <= '0;
    end else begin
      has_start_q <= has_start_n;
      closed_q    <= closed;
      start_q     <= start_n;
      end_q       <= end_n;
    end
  end

endmodule

// File: rtl/ref_clk_train_ctrl.sv
// Sequential per-lane delay-line training: scan taps upward for a clean eye
// window, then walk back down to its centre and report the result per lane.
module ref_clk_train_ctrl
  import ref_clk_train_pkg::*;
#(
  parameter int         NUM_LANES     = DEF_NUM_LANES,
  parameter int         TAP_W         = DEF_TAP_W,
  parameter int         SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int         MIN_WIN       = DEF_MIN_WIN,
  parameter logic [7:0] PATTERN       = DEF_PATTERN
) (
  input  logic                       fab_clk,
  input  logic                       arst_n,
  input  logic                       start,
  input  logic [8*NUM_LANES-1:0]     rx_data,
  input  logic [NUM_LANES-1:0]       eye_monitor_early,
  input  logic [NUM_LANES-1:0]       eye_monitor_late,
  input  logic [NUM_LANES-1:0]       delay_line_out_of_range,
  output logic [NUM_LANES-1:0]       delay_line_load,
  output logic [NUM_LANES-1:0]       delay_line_move,
  output logic [NUM_LANES-1:0]       delay_line_direction,
  output logic [NUM_LANES-1:0]       eye_monitor_clear_flags,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_LANES-1:0]       lane_err,
  output logic [TAP_W*NUM_LANES-1:0] tap_value
);

  localparam int                LANE_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [TAP_W-1:0]  TAP_MAX     = '1;
  localparam logic [LANE_W-1:0] LAST_LANE   = LANE_W'(NUM_LANES - 1);
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  train_state_e         state, state_n;
  logic [LANE_W-1:0]    lane;
  logic [TAP_W-1:0]     tap, centre_q, win_centre;
  logic [3:0]           settle_cnt;
  logic                 phase;
  logic [7:0]           lane_rx;
  logic                 lane_clean, scan_end, win_closed, win_ok;
  logic [NUM_LANES-1:0] lane_sel;

  assign lane_sel = NUM_LANES'(1) << lane;
  assign lane_rx  = rx_data[8*lane +: 8];

  // A sample taken at the delay-line limit never counts as clean.
  assign lane_clean = !eye_monitor_early[lane] && !eye_monitor_late[lane] &&
                      !delay_line_out_of_range[lane] &&
                      ((lane_rx == PATTERN) || (lane_rx == ~PATTERN));
  assign scan_end   = win_closed || (tap == TAP_MAX) || delay_line_out_of_range[lane];

  ref_clk_train_window #(
    .TAP_W   (TAP_W),
    .MIN_WIN (MIN_WIN)
  ) u_window (
    .clk     (fab_clk),
    .arst_n  (arst_n),
    .restart (state == LOAD),
    .sample  (state == SAMPLE),
    .clean   (lane_clean),
    .tap     (tap),
    .closed  (win_closed),
    .win_ok  (win_ok),
    .centre  (win_centre)
  );

  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n                 = state;
    delay_line_load         = '0;
    delay_line_move         = '0;
    delay_line_direction    = '0;
    eye_monitor_clear_flags = '0;
    case (state)
      IDLE:   if (start) state_n = LOAD;
      LOAD: begin
        delay_line_load = lane_sel;
        state_n         = CLEAR;
      end
      CLEAR: begin
        eye_monitor_clear_flags = lane_sel;
        state_n                 = SETTLE;
      end
      SETTLE: if (settle_cnt == SETTLE_LAST) state_n = SAMPLE;
      SAMPLE: begin
        if (!scan_end)   state_n = STEP;
        else if (win_ok) state_n = CENTER;
        else             state_n = NEXT;
      end
      STEP: begin
        delay_line_move      = lane_sel;
        delay_line_direction = lane_sel;
        state_n              = CLEAR;
      end
      CENTER: begin
        if (tap == centre_q) state_n = NEXT;
        else if (!phase)     delay_line_move = lane_sel;
      end
      NEXT:    state_n = (lane == LAST_LANE) ? FINISH : LOAD;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Move pulses in CENTER alternate with idle cycles, tracked by phase.
  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      lane_err   <= '0;
      tap_value  <= '0;
      lane       <= '0;
      tap        <= '0;
      centre_q   <= '0;
      settle_cnt <= '0;
      phase      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          busy     <= 1'b1;
          done     <= 1'b0;
          lane_err <= '0;
          lane     <= '0;
        end
        LOAD:   tap <= '0;
        CLEAR:  settle_cnt <= '0;
        SETTLE: settle_cnt <= settle_cnt + 4'd1;
        SAMPLE: if (scan_end) begin
          if (win_ok) begin
            centre_q <= win_centre;
            phase    <= 1'b0;
          end else begin
            lane_err[lane]                    <= 1'b1;
            tap_value[TAP_W*lane +: TAP_W] <= '0;
          end
        end
        STEP: tap <= tap + 1'b1;
        CENTER: begin
          if (tap == centre_q) begin
            tap_value[TAP_W*lane +: TAP_W] <= centre_q;
          end else begin
            phase <= ~phase;
            if (!phase) tap <= tap - 1'b1;
          end
        end
        NEXT: if (lane != LAST_LANE) lane <= lane + 1'b1;
        FINISH: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ref_clk_train_ctrl.sv
// Self-checking bench: behavioural delay-line/eye environment per lane and a
// closed-form model of each lane's expected scan outcome.
module tb_ref_clk_train_ctrl;

  localparam int         NL     = 4;
  localparam int         TW     = 7;
  localparam int         SETTLE = 4;
  localparam int         MINW   = 3;
  localparam logic [7:0] PAT    = 8'h55;
  localparam int         MAXT   = (1 << TW) - 1;

  logic              fab_clk = 1'b0;
  logic              arst_n  = 1'b0;
  logic              start   = 1'b0;
  logic [8*NL-1:0]   rx_data;
  logic [NL-1:0]     early = '0, late = '0, oor;
  logic [NL-1:0]     dl_load, dl_move, dl_dir, clr;
  logic              busy, done;
  logic [NL-1:0]     lane_err;
  logic [TW*NL-1:0]  tap_value;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int win_lo[NL];
  int win_hi[NL];
  int oor_tap[NL];
  bit use_flag[NL];
  int pos[NL] = '{default: 0};
  logic [NL-1:0] cap_load = '0, cap_move = '0, cap_dir = '0, cap_clr = '0;

  int load_seq[$];
  int up_cnt[NL];
  int down_cnt[NL];
  int last_clear_cyc = -100;
  int last_down_cyc  = -1;

  ref_clk_train_ctrl #(
    .NUM_LANES     (NL),
    .TAP_W         (TW),
    .SETTLE_CYCLES (SETTLE),
    .MIN_WIN       (MINW),
    .PATTERN       (PAT)
  ) dut (
    .fab_clk                 (fab_clk),
    .arst_n                  (arst_n),
    .start                   (start),
    .rx_data                 (rx_data),
    .eye_monitor_early       (early),
    .eye_monitor_late        (late),
    .delay_line_out_of_range (oor),
    .delay_line_load         (dl_load),
    .delay_line_move         (dl_move),
    .delay_line_direction    (dl_dir),
    .eye_monitor_clear_flags (clr),
    .busy                    (busy),
    .done                    (done),
    .lane_err                (lane_err),
    .tap_value               (tap_value)
  );

  always #5 fab_clk = ~fab_clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic int min3(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  // Scan stops one past the clean run, at the limit tap, or at the top tap.
  function automatic void model_lane(input int lo, input int hi, input int oor_at,
                                     output int up, output int down, output int tv, output bit err);
    int stop_tap, e;
    up = 0; down = 0; tv = 0; err = 1'b1;
    if (lo <= hi && lo < oor_at && lo <= MAXT) begin
      stop_tap = min3(hi + 1, oor_at, MAXT);
      e        = min3(hi, oor_at - 1, MAXT);
      up       = stop_tap;
      if (e - lo + 1 >= MINW) begin
        err  = 1'b0;
        tv   = lo + (e - lo) / 2;
        down = stop_tap - tv;
      end
    end else begin
      up = (oor_at < MAXT) ? oor_at : MAXT;
    end
  endfunction

  always_comb begin
    rx_data = '0;
    oor     = '0;
    for (int l = 0; l < NL; l++) begin
      oor[l] = (pos[l] >= oor_tap[l]);
      if ((pos[l] >= win_lo[l] && pos[l] <= win_hi[l]) || use_flag[l])
        rx_data[8*l +: 8] = (pos[l] % 2 == 1) ? ~PAT : PAT;
      else
        rx_data[8*l +: 8] = 8'h5A;
    end
  end

  always @(posedge fab_clk) begin
    for (int l = 0; l < NL; l++) begin
      if (cap_load[l])      pos[l] <= 0;
      else if (cap_move[l]) pos[l] <= cap_dir[l] ? pos[l] + 1 : pos[l] - 1;
      if (cap_clr[l]) begin
        early[l] <= 1'b0;
        late[l]  <= 1'b0;
      end else if (use_flag[l] && pos[l] < win_lo[l]) begin
        early[l] <= 1'b1;
      end else if (use_flag[l] && pos[l] > win_hi[l]) begin
        late[l] <= 1'b1;
      end
    end
  end

  always @(negedge fab_clk) begin
    logic [NL-1:0] act;
    int l;
    cyc++;
    cap_load = dl_load;
    cap_move = dl_move;
    cap_dir  = dl_dir;
    cap_clr  = clr;
    if (arst_n) begin
      act = dl_load | dl_move | clr;
      if (dl_dir != '0) check_output("dir_without_move", dl_dir & ~dl_move, '0);
      if (!busy) check_output("idle_ctrl_quiet", {dl_load, dl_move, dl_dir, clr}, '0);
      if (act != '0) begin
        check_output("ctrl_single_lane", $countones(act), 1);
        l = 0;
        for (int k = 0; k < NL; k++) if (act[k]) l = k;
        if (dl_load != '0) begin
          load_seq.push_back(l);
          last_down_cyc = -1;
        end else if (load_seq.size() > 0) begin
          check_output("ctrl_on_active_lane", l, load_seq[$]);
        end
        if (clr != '0) last_clear_cyc = cyc;
        if (dl_move != '0 && dl_dir != '0) begin
          up_cnt[l]++;
          check_output("settle_to_step", cyc - last_clear_cyc, SETTLE + 2);
          check_output("up_below_max", pos[l] < MAXT, 1);
        end
        if (dl_move != '0 && dl_dir == '0) begin
          down_cnt[l]++;
          check_output("down_above_zero", pos[l] > 0, 1);
          if (last_down_cyc >= 0) check_output("center_pace", cyc - last_down_cyc, 2);
          last_down_cyc = cyc;
        end
      end
    end
  end

  task automatic apply_stimulus(input int run_id);
    for (int l = 0; l < NL; l++) begin
      oor_tap[l]  = 999;
      use_flag[l] = 1'b0;
    end
    if (run_id == 1) begin
      win_lo = '{10, 30, 1, 0};
      win_hi = '{20, 40, 0, 6};
    end else begin
      win_lo = '{5, 100, 10, 120};
      win_hi = '{6, 120, 20, 127};
      oor_tap[1]  = 110;
      use_flag[2] = 1'b1;
    end
    load_seq.delete();
    for (int l = 0; l < NL; l++) begin
      up_cnt[l]   = 0;
      down_cnt[l] = 0;
    end
    last_clear_cyc = -100;
    last_down_cyc  = -1;
  endtask

  task automatic pulse_start();
    @(posedge fab_clk);
    #1 start = 1'b1;
    @(posedge fab_clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 20000) begin
      @(negedge fab_clk);
      n++;
    end
    check_output("done_timeout", done, 1);
  endtask

  task automatic wait_loads(input int k);
    int n = 0;
    while (load_seq.size() < k && n < 5000) begin
      @(negedge fab_clk);
      n++;
    end
    check_output("load_wait_timeout", load_seq.size() >= k, 1);
  endtask

  task automatic check_results(input string tag);
    int up, down, tv;
    bit err;
    check_output({tag, "_busy_clear"}, busy, 0);
    check_output({tag, "_done"}, done, 1);
    check_output({tag, "_lane_count"}, load_seq.size(), NL);
    for (int l = 0; l < NL; l++) begin
      model_lane(win_lo[l], win_hi[l], oor_tap[l], up, down, tv, err);
      if (l < load_seq.size()) check_output($sformatf("%s_order%0d", tag, l), load_seq[l], l);
      check_output($sformatf("%s_tap%0d", tag, l), tap_value[TW*l +: TW], tv);
      check_output($sformatf("%s_err%0d", tag, l), lane_err[l], err);
      check_output($sformatf("%s_up%0d", tag, l), up_cnt[l], up);
      check_output($sformatf("%s_down%0d", tag, l), down_cnt[l], down);
    end
  endtask

  initial begin
    apply_stimulus(1);
    repeat (3) @(posedge fab_clk);
    #1;
    check_output("reset_busy", busy, 0);
    check_output("reset_done", done, 0);
    check_output("reset_err", lane_err, 0);
    check_output("reset_tap", tap_value, 0);
    check_output("reset_ctrl", {dl_load, dl_move, dl_dir, clr}, 0);
    arst_n = 1'b1;

    // Run 1, with an extra START while busy that must be ignored.
    pulse_start();
    check_output("run1_busy_after_start", busy, 1);
    check_output("run1_done_low", done, 0);
    wait_loads(2);
    pulse_start();
    check_output("run1_still_busy", busy, 1);
    wait_done();
    check_results("run1");
    check_output("run1_lit_tap0", tap_value[0 +: TW], 7'd15);
    check_output("run1_lit_tap1", tap_value[TW +: TW], 7'd35);
    check_output("run1_lit_tap3", tap_value[3*TW +: TW], 7'd3);
    check_output("run1_lit_err", lane_err, 4'b0100);
    check_output("run1_lit_up0", up_cnt[0], 21);

    // Run 2: narrow window, limit hit, flag-driven eye, window to top tap.
    apply_stimulus(2);
    pulse_start();
    check_output("run2_done_cleared", done, 0);
    check_output("run2_err_cleared", lane_err, 0);
    check_output("run2_tap3_retained", tap_value[3*TW +: TW], 7'd3);
    wait_done();
    check_results("run2");
    check_output("run2_lit_tap1", tap_value[TW +: TW], 7'd104);
    check_output("run2_lit_tap3", tap_value[3*TW +: TW], 7'd123);
    check_output("run2_lit_err", lane_err, 4'b0001);

    // Asynchronous reset during lane 1 settling, then a clean retrain.
    apply_stimulus(1);
    pulse_start();
    wait_loads(2);
    begin
      int n = 0;
      while (clr[1] !== 1'b1 && n < 5000) begin
        @(negedge fab_clk);
        n++;
      end
      check_output("lane1_clear_seen", clr[1], 1);
    end
    @(negedge fab_clk);
    #2 arst_n = 1'b0;
    #1;
    check_output("arst_busy", busy, 0);
    check_output("arst_done", done, 0);
    check_output("arst_err", lane_err, 0);
    check_output("arst_tap", tap_value, 0);
    check_output("arst_ctrl", {dl_load, dl_move, dl_dir, clr}, 0);
    repeat (2) @(negedge fab_clk);
    #2 arst_n = 1'b1;
    repeat (20) @(negedge fab_clk);
    check_output("post_reset_idle", busy, 0);
    check_output("post_reset_no_load", load_seq.size(), 2);
    apply_stimulus(1);
    pulse_start();
    wait_done();
    check_results("retrain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
